// File: rtl/nibble_serial_adder_if.sv
// Operand/result handshake bundle for nibble_serial_adder.
interface nibble_serial_adder_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );

  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );
endinterface

// File: rtl/nibble_serial_adder.sv
// Wide adder that walks one 4-bit carry-lookahead slice across the operands,
// LSB nibble first, with the inter-nibble carry held in a register.
module nibble_serial_adder #(
  parameter int WIDTH = 16
) (
  input logic                  clk,
  input logic                  rst,
  nibble_serial_adder_if.slave bus
);
  localparam int NIB = WIDTH / 4;
  localparam int KW  = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(NIB - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic [KW-1:0]    k_q, k_d;

  logic [3:0] g, p, s4;
  logic [4:0] c;

  // 4-bit carry-lookahead slice on the low nibble of the shift registers
  always_comb begin
    g    = a_q[3:0] & b_q[3:0];
    p    = a_q[3:0] ^ b_q[3:0];
    c[0] = carry_q;
    c[1] = g[0] | (p[0] & c[0]);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & c[0]);
    s4   = p ^ c[3:0];
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    k_d     = k_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          state_d = RUN;
          a_d     = bus.a;
          b_d     = bus.b;
          carry_d = bus.cin;
          k_d     = '0;
          sum_d   = '0;
          cout_d  = 1'b0;
          ovf_d   = 1'b0;
        end
      end
      RUN: begin
        a_d     = a_q >> 4;
        b_d     = b_q >> 4;
        // shift form keeps WIDTH=4 legal (no empty slice of sum_q)
        sum_d   = (sum_q >> 4) | (WIDTH'(s4) << (WIDTH - 4));
        carry_d = c[4];
        k_d     = k_q + KW'(1);
        if (k_q == K_LAST) begin
          state_d = DONE;
          cout_d  = c[4];
          ovf_d   = c[3] ^ c[4];
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      k_q     <= k_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
  assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_nibble_serial_adder.sv
// Self-checking bench for nibble_serial_adder at WIDTH=16 and WIDTH=4.
module tb_nibble_serial_adder;
  logic clk;
  logic rst;

  nibble_serial_adder_if #(.WIDTH(16)) bus16 ();
  nibble_serial_adder_if #(.WIDTH(4))  bus4 ();

  nibble_serial_adder #(.WIDTH(16)) dut16 (.clk(clk), .rst(rst), .bus(bus16));
  nibble_serial_adder #(.WIDTH(4))  dut4  (.clk(clk), .rst(rst), .bus(bus4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int n_exp16 = 0;
  int n_out16 = 0;

  always @(posedge clk)
    if (!rst && bus16.out_valid && bus16.out_ready) n_out16++;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full 16-bit operation: accept, wait for result, optional DONE stall, drain.
  task automatic run16(input logic [15:0] a, input logic [15:0] b, input logic cin,
                       input int stall, input bit rnd_ready, input bit chk_lat,
                       input logic [15:0] es, input logic ec, input logic eo,
                       input string tag);
    int lat;
    bit busy_bad;
    check_eq({tag, "_in_ready_idle"}, 32'(bus16.in_ready), 32'd1);
    bus16.a = a; bus16.b = b; bus16.cin = cin; bus16.in_valid = 1'b1;
    tick();
    bus16.in_valid = 1'b0;
    busy_bad = (bus16.in_ready !== 1'b0);
    lat = 0;
    while (bus16.out_valid !== 1'b1 && lat < 40) begin
      if (rnd_ready) bus16.out_ready = 1'($urandom_range(0, 1));
      tick();
      lat++;
      if (bus16.in_ready !== 1'b0) busy_bad = 1'b1;
    end
    check_eq({tag, "_out_valid_seen"}, 32'(bus16.out_valid), 32'd1);
    if (chk_lat) check_eq({tag, "_latency"}, 32'(lat), 32'd4);
    bus16.out_ready = 1'b0;
    for (int i = 0; i < stall; i++) begin
      tick();
      if (bus16.in_ready !== 1'b0 || bus16.out_valid !== 1'b1) busy_bad = 1'b1;
    end
    check_eq({tag, "_sum"},  32'(bus16.sum),  32'(es));
    check_eq({tag, "_cout"}, 32'(bus16.cout), 32'(ec));
    check_eq({tag, "_ovf"},  32'(bus16.ovf),  32'(eo));
    bus16.out_ready = 1'b1;
    n_exp16++;
    tick();
    if (bus16.in_ready !== 1'b1 || bus16.out_valid !== 1'b0) busy_bad = 1'b1;
    check_eq({tag, "_handshake"}, 32'(busy_bad), 32'd0);
  endtask

  task automatic run4(input logic [3:0] a, input logic [3:0] b, input logic cin,
                      input logic [3:0] es, input logic ec, input logic eo, input string tag);
    int lat;
    bus4.a = a; bus4.b = b; bus4.cin = cin; bus4.in_valid = 1'b1;
    tick();
    bus4.in_valid = 1'b0;
    lat = 0;
    while (bus4.out_valid !== 1'b1 && lat < 20) begin
      tick();
      lat++;
    end
    check_eq({tag, "_latency"}, 32'(lat), 32'd1);
    check_eq({tag, "_sum"},  32'(bus4.sum),  32'(es));
    check_eq({tag, "_cout"}, 32'(bus4.cout), 32'(ec));
    check_eq({tag, "_ovf"},  32'(bus4.ovf),  32'(eo));
    tick();
    check_eq({tag, "_idle"}, 32'(bus4.in_ready), 32'd1);
  endtask

  initial begin
    logic [15:0] ra, rb;
    logic        rc;
    logic [16:0] ru;
    logic signed [16:0] rs;
    bit stall_bad;

    rst = 1'b1;
    bus16.in_valid = 1'b0; bus16.a = '0; bus16.b = '0; bus16.cin = 1'b0; bus16.out_ready = 1'b1;
    bus4.in_valid  = 1'b0; bus4.a  = '0; bus4.b  = '0; bus4.cin  = 1'b0; bus4.out_ready  = 1'b1;
    tick();
    tick();
    check_eq("rst_in_ready",  32'(bus16.in_ready),  32'd1);
    check_eq("rst_out_valid", 32'(bus16.out_valid), 32'd0);
    check_eq("rst_sum",       32'(bus16.sum),       32'd0);
    check_eq("rst_cout",      32'(bus16.cout),      32'd0);
    check_eq("rst_ovf",       32'(bus16.ovf),       32'd0);
    rst = 1'b0;
    tick();

    run16(16'h1234, 16'h4321, 1'b0, 0, 1'b0, 1'b1, 16'h5555, 1'b0, 1'b0, "basic");
    run16(16'hFFFF, 16'h0000, 1'b1, 0, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, "ripple");
    run16(16'h7FFF, 16'h0001, 1'b0, 0, 1'b0, 1'b1, 16'h8000, 1'b0, 1'b1, "pos_ovf");
    run16(16'h8000, 16'h8000, 1'b0, 0, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b1, "neg_ovf");
    run16(16'hFFFF, 16'hFFFF, 1'b1, 0, 1'b0, 1'b1, 16'hFFFF, 1'b1, 1'b0, "all_ones");

    // Backpressure: stalled DONE ignores a new in_valid pulse until released
    bus16.out_ready = 1'b0;
    bus16.a = 16'h1111; bus16.b = 16'h2222; bus16.cin = 1'b0; bus16.in_valid = 1'b1;
    tick();
    bus16.in_valid = 1'b0;
    for (int i = 0; i < 10 && bus16.out_valid !== 1'b1; i++) tick();
    check_eq("bp_out_valid", 32'(bus16.out_valid), 32'd1);
    stall_bad = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (i == 3) begin
        bus16.a = 16'h0F0F; bus16.b = 16'h0101; bus16.cin = 1'b0; bus16.in_valid = 1'b1;
      end else if (i == 4) begin
        bus16.in_valid = 1'b0;
      end
      tick();
      if (bus16.sum !== 16'h3333 || bus16.cout !== 1'b0 || bus16.ovf !== 1'b0 ||
          bus16.in_ready !== 1'b0 || bus16.out_valid !== 1'b1) stall_bad = 1'b1;
    end
    check_eq("bp_stable", 32'(stall_bad), 32'd0);
    bus16.in_valid = 1'b1;
    bus16.out_ready = 1'b1;
    n_exp16++;
    tick();
    check_eq("bp_release_idle",   32'(bus16.in_ready),  32'd1);
    check_eq("bp_release_nvalid", 32'(bus16.out_valid), 32'd0);
    check_eq("bp_release_hold",   32'(bus16.sum),       32'h3333);
    tick();
    bus16.in_valid = 1'b0;
    check_eq("bp_new_accept", 32'(bus16.in_ready), 32'd0);
    check_eq("bp_sum_cleared", 32'(bus16.sum), 32'd0);
    for (int i = 0; i < 10 && bus16.out_valid !== 1'b1; i++) tick();
    check_eq("bp_new_sum", 32'(bus16.sum), 32'h1010);
    n_exp16++;
    tick();

    // Reset in the middle of RUN
    bus16.a = 16'hAAAA; bus16.b = 16'h5555; bus16.cin = 1'b0; bus16.in_valid = 1'b1;
    tick();
    bus16.in_valid = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    #1;
    check_eq("mid_rst_out_valid", 32'(bus16.out_valid), 32'd0);
    check_eq("mid_rst_in_ready",  32'(bus16.in_ready),  32'd1);
    check_eq("mid_rst_sum",       32'(bus16.sum),       32'd0);
    check_eq("mid_rst_cout",      32'(bus16.cout),      32'd0);
    tick();
    rst = 1'b0;
    tick();
    run16(16'h0001, 16'h0001, 1'b0, 0, 1'b0, 1'b1, 16'h0002, 1'b0, 1'b0, "post_rst");

    run4(4'hF, 4'h1, 1'b0, 4'h0, 1'b1, 1'b0, "w4_carry");
    run4(4'h7, 4'h1, 1'b0, 4'h8, 1'b0, 1'b1, "w4_ovf");
    run4(4'h3, 4'h4, 1'b1, 4'h8, 1'b0, 1'b1, "w4_cin");

    for (int n = 0; n < 1000; n++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      rc = 1'($urandom_range(0, 1));
      ru = {1'b0, ra} + {1'b0, rb} + {16'd0, rc};
      rs = $signed({ra[15], ra}) + $signed({rb[15], rb}) + $signed({16'd0, rc});
      run16(ra, rb, rc, $urandom_range(0, 3), 1'b1, 1'b0, ru[15:0], ru[16],
            (rs > 17'sd32767) || (rs < -17'sd32768), "rnd");
    end

    check_eq("result_count", 32'(n_out16), 32'(n_exp16));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
